updi_cs_poller: RTL and testbench
=================================

Name: updi_cs_poller

Overview:
- Sequencer that repeatedly reads one UPDI control/status register (LDCS) through updi_interface until (value & mask) == expected, a poll limit is exhausted, or a response times out.
- Used by updi_programmer for STATUSA checks, ASI_KEY_STATUS (NVMPROG/CHIPERASE unlock), and SYS_STATUS waits after reset.
- Owns the interface's instruction/tx/rx handshake and the RX output FIFO read port while busy.

Parameters:
- DATA_ADDR_BITS, 6, width of rx_n_bytes (matches updi_interface)
- POLL_INTERVAL, 1024, idle cycles between polls (>=1)
- RESP_TIMEOUT, 65536, max cycles from rx_start to first FIFO byte
- MAX_POLLS, 255, polls before giving up (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  pulse; latches cs_addr, mask, expected
- cs_addr  in  4  CS register address
- mask  in  8  compare mask
- expected  in  8  compare value (pre-masked by caller)
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse
- result  out  2  0 match, 1 polls exhausted, 2 response timeout, 3 ack_error; valid when done, held until next start
- last_value  out  8  last byte read
- poll_count  out  8  polls issued in current run
- instr_converter_en  out  1  instruction converter enable
- instruction  out  updi_instruction  always UPDI_LDCS while driven
- instr_cs_addr  out  4  latched cs_addr
- tx_start  out  1  one-cycle transmit request
- tx_ready  in  1  interface ready to transmit
- rx_n_bytes  out  DATA_ADDR_BITS  constant 1
- rx_start  out  1  one-cycle receive request
- rx_ready  in  1  interface ready to receive
- ack_error  in  1  interface ACK failure
- rx_fifo_data  in  8  RX out FIFO head (registered; valid the cycle after rd_en)
- rx_fifo_rd_en  out  1  FIFO pop
- rx_fifo_empty  in  1  FIFO empty

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state IDLE; busy, done, tx_start, rx_start, rx_fifo_rd_en, instr_converter_en 0; result, last_value, poll_count 0.
- All handshake outputs are combinational from state. The datapath registers (latched inputs, counters, last_value, result) are flops.
- IDLE: busy=0. On start, latch inputs, clear poll_count, go to DRAIN. start is ignored whenever busy=1.
- DRAIN: while !rx_fifo_empty, assert rd_en and discard the byte. When empty, go to SEND. This removes stale bytes left by earlier operations.
- SEND: instr_converter_en=1 and instruction/instr_cs_addr are driven. When tx_ready=1, assert tx_start for exactly one cycle, increment poll_count, and go to RX_START.
- RX_START: when rx_ready=1, assert rx_start for one cycle with rx_n_bytes=1, clear the timeout counter, and go to WAIT_DATA.
- WAIT_DATA: the timeout counter increments each cycle. If !rx_fifo_empty, assert rd_en and go to CAPTURE. If the counter reaches RESP_TIMEOUT-1 with the FIFO still empty, set result=2 and go to FINISH. A non-empty FIFO on the same cycle as the timeout wins.
- CAPTURE: last_value <= rx_fifo_data; go to CHECK.
- CHECK: if (last_value & mask)==expected, set result=0 and go to FINISH. Else if poll_count==MAX_POLLS, set result=1 and go to FINISH. Else load the interval counter and go to DELAY.
- DELAY: wait POLL_INTERVAL cycles, then go to SEND.
- FINISH: done=1 for one cycle, busy still 1, then go to IDLE.
- ack_error=1 in any busy state except FINISH: set result=3 and go to FINISH next cycle. This overrides all other transitions in that cycle.
- Latency: minimum start→done with an immediate match is 7 cycles (DRAIN, SEND, RX_START, WAIT_DATA, CAPTURE, CHECK, FINISH).
- poll_count saturates by construction; it never exceeds MAX_POLLS.
- Reset mid-operation returns to IDLE immediately. The interface and FIFO are reset by the same rst; no partial instruction is retried.

Decomposition:
- updi_instruction enum and the UPDI CS register addresses (STATUSA=0x0, ASI_KEY_STATUS=0x7, ASI_SYS_STATUS=0xB) live in the shared UPDI package.
- The result code enum (CS_POLL_MATCH/EXHAUSTED/TIMEOUT/ACK_ERR) also goes in the package.
- Single module, no sub-module; the counters are inline.

Test Plan:
- Immediate match: start, cs_addr=0x0, mask=0xFF, expected=0x30; model returns 0x30 → one tx_start, done after 7 cycles, result=0, poll_count=1, last_value=0x30.
- Masked match after polls: mask=0x08, expected=0x08; model returns 0x00, 0x00, 0x1C → three tx_start pulses spaced ≥POLL_INTERVAL apart, result=0, poll_count=3.
- Exhaustion: MAX_POLLS=4; model always returns 0x00 → exactly 4 polls, result=1, last_value=0x00, no fifth tx_start.
- Timeout and drain: 2 stale bytes preloaded in the FIFO, then no response → both popped before the first tx_start; done RESP_TIMEOUT cycles after rx_start with result=2.
- Abort paths: ack_error pulsed in DELAY → done next cycle with result=3. Second start while busy is ignored. rst asserted in WAIT_DATA → busy=0 next cycle with all outputs at reset values.

Source files
------------

// File: rtl/updi_cs_poller_pkg.sv
// Shared UPDI definitions: instruction opcodes, control/status register addresses,
// and the result codes and states of the CS-register polling sequencer.
package updi_cs_poller_pkg;

    typedef enum logic [2:0] {
        UPDI_LDS    = 3'd0,
        UPDI_STS    = 3'd1,
        UPDI_LD     = 3'd2,
        UPDI_ST     = 3'd3,
        UPDI_LDCS   = 3'd4,
        UPDI_STCS   = 3'd5,
        UPDI_KEY    = 3'd6,
        UPDI_REPEAT = 3'd7
    } updi_instruction;

    localparam logic [3:0] UPDI_CS_STATUSA        = 4'h0;
    localparam logic [3:0] UPDI_CS_ASI_KEY_STATUS = 4'h7;
    localparam logic [3:0] UPDI_CS_ASI_SYS_STATUS = 4'hB;

    typedef enum logic [1:0] {
        CS_POLL_MATCH     = 2'd0,
        CS_POLL_EXHAUSTED = 2'd1,
        CS_POLL_TIMEOUT   = 2'd2,
        CS_POLL_ACK_ERR   = 2'd3
    } cs_poll_result_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SEND,
        ST_RX_START,
        ST_WAIT_DATA,
        ST_CAPTURE,
        ST_CHECK,
        ST_DELAY,
        ST_FINISH
    } cs_poll_state_e;

endpackage

// File: rtl/updi_cs_poller.sv
// Repeatedly issues LDCS through the UPDI interface until the masked value matches,
// the poll limit runs out, the response times out, or the interface reports an ACK error.
module updi_cs_poller
    import updi_cs_poller_pkg::*;
#(
    parameter int DATA_ADDR_BITS = 6,
    parameter int POLL_INTERVAL  = 1024,
    parameter int RESP_TIMEOUT   = 65536,
    parameter int MAX_POLLS      = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                cs_addr,
    input  logic [7:0]                mask,
    input  logic [7:0]                expected,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result,
    output logic [7:0]                last_value,
    output logic [7:0]                poll_count,
    output logic                      instr_converter_en,
    output updi_instruction           instruction,
    output logic [3:0]                instr_cs_addr,
    output logic                      tx_start,
    input  logic                      tx_ready,
    output logic [DATA_ADDR_BITS-1:0] rx_n_bytes,
    output logic                      rx_start,
    input  logic                      rx_ready,
    input  logic                      ack_error,
    input  logic [7:0]                rx_fifo_data,
    output logic                      rx_fifo_rd_en,
    input  logic                      rx_fifo_empty
);

    localparam int TO_W = $clog2(RESP_TIMEOUT) + 1;
    localparam int IV_W = $clog2(POLL_INTERVAL) + 1;

    cs_poll_state_e  r_state, w_state_next;
    cs_poll_result_e r_result, w_result_val;
    logic [3:0]      r_cs_addr;
    logic [7:0]      r_mask, r_expected, r_last_value, r_poll_count;
    logic [TO_W-1:0] r_to_cnt, w_to_next;
    logic [IV_W-1:0] r_iv_cnt;
    logic            w_latch, w_poll_inc, w_to_clr, w_iv_load, w_capture, w_set_result;

    assign w_to_next = r_to_cnt + TO_W'(1);

    always_comb begin
        w_state_next       = r_state;
        w_result_val       = CS_POLL_MATCH;
        w_set_result       = 1'b0;
        w_latch            = 1'b0;
        w_poll_inc         = 1'b0;
        w_to_clr           = 1'b0;
        w_iv_load          = 1'b0;
        w_capture          = 1'b0;
        busy               = (r_state != ST_IDLE);
        done               = 1'b0;
        instr_converter_en = 1'b0;
        tx_start           = 1'b0;
        rx_start           = 1'b0;
        rx_fifo_rd_en      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stale bytes from earlier operations must not be mistaken for our reply.
                if (!rx_fifo_empty) rx_fifo_rd_en = 1'b1;
                else                w_state_next  = ST_SEND;
            end
            ST_SEND: begin
                instr_converter_en = 1'b1;
                if (tx_ready) begin
                    tx_start     = 1'b1;
                    w_poll_inc   = 1'b1;
                    w_state_next = ST_RX_START;
                end
            end
            ST_RX_START: begin
                if (rx_ready) begin
                    rx_start     = 1'b1;
                    w_to_clr     = 1'b1;
                    w_state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!rx_fifo_empty) begin
                    rx_fifo_rd_en = 1'b1;
                    w_state_next  = ST_CAPTURE;
                end else if (w_to_next == TO_W'(RESP_TIMEOUT - 1)) begin
                    w_set_result = 1'b1;
                    w_result_val = CS_POLL_TIMEOUT;
                    w_state_next = ST_FINISH;
                end
            end
            ST_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if ((r_last_value & r_mask) == r_expected) begin
                    w_set_result = 1'b1;
                    w_result_val = CS_POLL_MATCH;
                    w_state_next = ST_FINISH;
                end else if (r_poll_count == 8'(MAX_POLLS)) begin
                    w_set_result = 1'b1;
                    w_result_val = CS_POLL_EXHAUSTED;
                    w_state_next = ST_FINISH;
                end else begin
                    w_iv_load    = 1'b1;
                    w_state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_iv_cnt == '0) w_state_next = ST_SEND;
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // An ACK failure aborts the run and suppresses every side effect of this cycle.
        if (ack_error && (r_state != ST_IDLE) && (r_state != ST_FINISH)) begin
            w_state_next  = ST_FINISH;
            w_set_result  = 1'b1;
            w_result_val  = CS_POLL_ACK_ERR;
            tx_start      = 1'b0;
            rx_start      = 1'b0;
            rx_fifo_rd_en = 1'b0;
            w_poll_inc    = 1'b0;
            w_to_clr      = 1'b0;
            w_iv_load     = 1'b0;
            w_capture     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_result     <= CS_POLL_MATCH;
            r_cs_addr    <= '0;
            r_mask       <= '0;
            r_expected   <= '0;
            r_last_value <= '0;
            r_poll_count <= '0;
            r_to_cnt     <= '0;
            r_iv_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_cs_addr    <= cs_addr;
                r_mask       <= mask;
                r_expected   <= expected;
                r_poll_count <= '0;
            end
            if (w_poll_inc)                     r_poll_count <= r_poll_count + 8'd1;
            if (w_to_clr)                       r_to_cnt     <= '0;
            else if (r_state == ST_WAIT_DATA)   r_to_cnt     <= w_to_next;
            if (w_iv_load)                      r_iv_cnt     <= IV_W'(POLL_INTERVAL - 1);
            else if (r_state == ST_DELAY && r_iv_cnt != '0)
                                                r_iv_cnt     <= r_iv_cnt - IV_W'(1);
            if (w_capture)                      r_last_value <= rx_fifo_data;
            if (w_set_result)                   r_result     <= w_result_val;
        end
    end

    assign result        = r_result;
    assign last_value    = r_last_value;
    assign poll_count    = r_poll_count;
    assign instruction   = UPDI_LDCS;
    assign instr_cs_addr = r_cs_addr;
    assign rx_n_bytes    = DATA_ADDR_BITS'(1);

endmodule

// File: tb/tb_updi_cs_poller.sv
// Bench for updi_cs_poller: a behavioural UPDI interface/FIFO model answers each LDCS,
// and a run-level reference model predicts result, poll count and last value.
module tb_updi_cs_poller;
    import updi_cs_poller_pkg::*;

    localparam int DAB = 6;
    localparam int P   = 8;
    localparam int T   = 40;
    localparam int MP  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [3:0]      cs_addr = '0;
    logic [7:0]      mask = '0;
    logic [7:0]      expected = '0;
    logic            busy, done;
    logic [1:0]      result;
    logic [7:0]      last_value, poll_count;
    logic            instr_converter_en;
    updi_instruction instruction;
    logic [3:0]      instr_cs_addr;
    logic            tx_start, rx_start, rx_fifo_rd_en;
    logic            tx_ready = 1'b1;
    logic            rx_ready = 1'b1;
    logic [DAB-1:0]  rx_n_bytes;
    logic            ack_error = 1'b0;
    logic [7:0]      rx_fifo_data = '0;
    logic            rx_fifo_empty = 1'b1;

    updi_cs_poller #(.DATA_ADDR_BITS(DAB), .POLL_INTERVAL(P), .RESP_TIMEOUT(T), .MAX_POLLS(MP)) dut (
        .clk(clk), .rst(rst), .start(start), .cs_addr(cs_addr), .mask(mask), .expected(expected),
        .busy(busy), .done(done), .result(result), .last_value(last_value), .poll_count(poll_count),
        .instr_converter_en(instr_converter_en), .instruction(instruction), .instr_cs_addr(instr_cs_addr),
        .tx_start(tx_start), .tx_ready(tx_ready), .rx_n_bytes(rx_n_bytes), .rx_start(rx_start),
        .rx_ready(rx_ready), .ack_error(ack_error), .rx_fifo_data(rx_fifo_data),
        .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_empty(rx_fifo_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    // Environment model state
    logic [7:0] fifo_q[$];
    int         resp_q[$];
    int         pend_val[$];
    int         pend_due[$];
    bit         rand_ready = 1'b0;
    int         max_lat = 0;
    logic [3:0] cur_cs = '0;
    int         tx_cnt, pop_cnt, pops_before_tx, last_tx_cyc, last_rx_cyc, min_gap;

    // Interface/FIFO model: sample DUT requests mid-cycle, apply their effects just after the next edge.
    initial begin
        bit s_rd, s_tx, s_rx;
        int v;
        forever begin
            @(negedge clk);
            s_rd = rx_fifo_rd_en;
            s_tx = tx_start;
            s_rx = rx_start;
            if (!rst) begin
                if (s_rd) begin
                    check("rd_en_nonempty", rx_fifo_empty, 0);
                    pop_cnt++;
                    if (tx_cnt == 0) pops_before_tx++;
                end
                if (s_tx) begin
                    check("tx_instruction", instruction, UPDI_LDCS);
                    check("tx_cs_addr", instr_cs_addr, cur_cs);
                    check("tx_converter_en", instr_converter_en, 1);
                    if (tx_cnt > 0 && (cyc - last_tx_cyc) < min_gap) min_gap = cyc - last_tx_cyc;
                    tx_cnt++;
                    last_tx_cyc = cyc;
                end
                if (s_rx) begin
                    check("rx_n_bytes", rx_n_bytes, 1);
                    last_rx_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                fifo_q.delete();
                pend_val.delete();
                pend_due.delete();
                rx_fifo_data = '0;
            end else begin
                if (s_rd && fifo_q.size() > 0) rx_fifo_data = fifo_q.pop_front();
                if (s_rx && resp_q.size() > 0) begin
                    v = resp_q.pop_front();
                    if (v >= 0) begin
                        pend_val.push_back(v);
                        pend_due.push_back(cyc + int'($urandom_range(0, max_lat)));
                    end
                end
                while (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    v = pend_val.pop_front();
                    void'(pend_due.pop_front());
                    fifo_q.push_back(v[7:0]);
                end
            end
            rx_fifo_empty = (fifo_q.size() == 0);
            tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            rx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Reference model: walks the reply list with the polling rules, independent of any FSM detail.
    int resp_arr[MP];
    int model_last = 0;
    int m_res, m_polls;

    task automatic ref_model(input logic [7:0] m, input logic [7:0] e);
        m_res   = 1;
        m_polls = MP;
        for (int i = 0; i < MP; i++) begin
            if (resp_arr[i] < 0) begin
                m_res = 2; m_polls = i + 1; return;
            end
            model_last = resp_arr[i];
            if ((resp_arr[i] & m) == e) begin
                m_res = 0; m_polls = i + 1; return;
            end
        end
    endtask

    int start_cyc, done_cyc;
    logic [1:0] d_result;
    logic [7:0] d_poll, d_last;

    task automatic load_env(input int n_stale);
        @(negedge clk);
        resp_q.delete();
        for (int i = 0; i < MP; i++) resp_q.push_back(resp_arr[i]);
        for (int i = 0; i < n_stale; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic launch(input logic [3:0] cs, input logic [7:0] m, input logic [7:0] e);
        @(posedge clk);
        #1;
        cur_cs = cs; tx_cnt = 0; pop_cnt = 0; pops_before_tx = 0; min_gap = 1000000;
        cs_addr = cs; mask = m; expected = e; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cs_addr = 4'($urandom_range(0, 15));
        mask = 8'($urandom_range(0, 255));
        expected = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check({tag, "_done_seen"}, seen, 1);
        done_cyc = cyc;
        d_result = result; d_poll = poll_count; d_last = last_value;
        check({tag, "_busy_at_done"}, busy, 1);
    endtask

    task automatic check_run(input string tag, input logic [7:0] m, input logic [7:0] e, input int n_stale);
        ref_model(m, e);
        check({tag, "_result"}, d_result, m_res);
        check({tag, "_poll_count"}, d_poll, m_polls);
        check({tag, "_last_value"}, d_last, model_last);
        check({tag, "_tx_pulses"}, tx_cnt, m_polls);
        check({tag, "_drained"}, pops_before_tx, n_stale);
        check({tag, "_pops"}, pop_cnt, n_stale + m_polls - ((m_res == 2) ? 1 : 0));
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_result_held"}, result, m_res);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_rx_start"}, rx_start, 0);
        check({tag, "_rd_en"}, rx_fifo_rd_en, 0);
        check({tag, "_conv_en"}, instr_converter_en, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_last_value"}, last_value, 0);
        check({tag, "_poll_count"}, poll_count, 0);
    endtask

    initial begin
        bit seen;
        logic [7:0] rm, re;
        int ns;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Immediate match: seven cycles start to done
        resp_arr = '{8'h30, 8'h30, 8'h30, 8'h30};
        load_env(0);
        launch(UPDI_CS_STATUSA, 8'hFF, 8'h30);
        wait_done("imm");
        check("imm_latency", done_cyc - start_cyc, 7);
        check_run("imm", 8'hFF, 8'h30, 0);

        // Masked match on third poll; a second start while busy must be ignored
        resp_arr = '{8'h00, 8'h00, 8'h1C, 8'h08};
        load_env(0);
        launch(UPDI_CS_ASI_KEY_STATUS, 8'h08, 8'h08);
        repeat (10) @(posedge clk);
        #1; start = 1'b1; cs_addr = UPDI_CS_ASI_SYS_STATUS; mask = 8'h00; expected = 8'h00;
        @(posedge clk); #1; start = 1'b0;
        wait_done("masked");
        check("masked_tx_gap", min_gap, P + 5);
        check_run("masked", 8'h08, 8'h08, 0);

        // Exhaustion: no fifth poll afterwards
        resp_arr = '{8'h00, 8'h00, 8'h00, 8'h00};
        load_env(0);
        launch(UPDI_CS_ASI_SYS_STATUS, 8'h01, 8'h01);
        wait_done("exh");
        check_run("exh", 8'h01, 8'h01, 0);
        repeat (P + 10) @(negedge clk);
        check("exh_no_extra_tx", tx_cnt, MP);

        // Stale bytes drained, then no response: timeout T cycles after rx_start
        resp_arr = '{-1, -1, -1, -1};
        load_env(2);
        launch(UPDI_CS_STATUSA, 8'hFF, 8'h00);
        wait_done("tmo");
        check("tmo_latency", done_cyc - last_rx_cyc, T);
        check_run("tmo", 8'hFF, 8'h00, 2);

        // Randomized runs with random handshake readiness, reply latency and stale bytes
        rand_ready = 1'b1;
        max_lat = 5;
        for (int r = 0; r < 12; r++) begin
            rm = 8'($urandom_range(0, 255));
            re = 8'($urandom_range(0, 255)) & rm;
            for (int i = 0; i < MP; i++)
                resp_arr[i] = ($urandom_range(0, 2) == 0) ? int'((re | (8'($urandom_range(0, 255)) & ~rm)))
                                                           : int'($urandom_range(0, 255));
            ns = $urandom_range(0, 2);
            load_env(ns);
            launch(4'($urandom_range(0, 15)), rm, re);
            wait_done("rnd");
            check_run("rnd", rm, re, ns);
        end
        rand_ready = 1'b0;
        max_lat = 0;

        // ACK error while waiting between polls
        resp_arr = '{8'h01, 8'h01, 8'h01, 8'h01};
        load_env(0);
        launch(UPDI_CS_ASI_KEY_STATUS, 8'hFF, 8'h55);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_fifo_rd_en) begin seen = 1'b1; break; end
        end
        check("ack_reply_popped", seen, 1);
        repeat (4) begin @(posedge clk); #1; end
        check("ack_busy_in_delay", busy, 1);
        ack_error = 1'b1;
        @(posedge clk); #1; ack_error = 1'b0;
        @(negedge clk);
        check("ack_done_next", done, 1);
        check("ack_result", result, 3);
        check("ack_poll_count", poll_count, 1);
        check("ack_last_value", last_value, 8'h01);
        @(negedge clk);
        check("ack_busy_after", busy, 0);
        model_last = 1;

        // Reset while waiting for data
        resp_arr = '{-1, -1, -1, -1};
        load_env(0);
        launch(UPDI_CS_ASI_SYS_STATUS, 8'hFF, 8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_start) begin seen = 1'b1; break; end
        end
        check("rst_rx_start_seen", seen, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1; rst = 1'b0;
        model_last = 0;

        // Recovery after reset
        resp_arr = '{8'h80, 8'h80, 8'h80, 8'h80};
        load_env(0);
        launch(UPDI_CS_STATUSA, 8'h80, 8'h80);
        wait_done("recover");
        check_run("recover", 8'h80, 8'h80, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
